// File: rtl/channel_fir_if.sv
// FIFO-side signal bundle for channel_fir: upstream I/Q read port and downstream I/Q write port.
interface channel_fir_if #(
    parameter int DATA_SIZE = 32
);
    // Handshake: a read happens in the cycle in_rd_en is high, which the filter
    // raises only when both *_empty are low, and i_in/q_in carry that word in the
    // same cycle. A write happens in the cycle out_wr_en is high, which it raises
    // only when both *_out_full are low, and i_out/q_out carry that word.
    logic                        i_empty;
    logic                        q_empty;
    logic                        in_rd_en;
    logic signed [DATA_SIZE-1:0] i_in;
    logic signed [DATA_SIZE-1:0] q_in;
    logic                        i_out_full;
    logic                        q_out_full;
    logic                        out_wr_en;
    logic signed [DATA_SIZE-1:0] i_out;
    logic signed [DATA_SIZE-1:0] q_out;

    modport master (
        output i_empty, q_empty, i_in, q_in, i_out_full, q_out_full,
        input  in_rd_en, out_wr_en, i_out, q_out
    );

    modport slave (
        input  i_empty, q_empty, i_in, q_in, i_out_full, q_out_full,
        output in_rd_en, out_wr_en, i_out, q_out
    );
endinterface

// File: rtl/channel_fir.sv
// Decimating complex FIR: shifts DECIM I/Q samples in, then runs one tap per
// cycle over both delay lines and writes a single dequantized I/Q result.
package globals_pkg;
    localparam int COEFF_COUNT = 20;
    // Q10 low-pass taps, index 0 multiplies the newest sample.
    localparam logic signed [31:0] CHANNEL_COEFFS [COEFF_COUNT] = '{
        -32'sd12, -32'sd20, -32'sd18,   32'sd0,  32'sd35,
         32'sd80, 32'sd120, 32'sd150, 32'sd168, 32'sd175,
        32'sd175, 32'sd168, 32'sd150, 32'sd120,  32'sd80,
         32'sd35,   32'sd0, -32'sd18, -32'sd20, -32'sd12
    };
endpackage

module channel_fir
    import globals_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int TAPS      = 20,
    parameter int DECIM     = 10,
    parameter int BITS      = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    channel_fir_if.slave               bus,
    output logic [1:0]                 dbg_state,
    output logic [$clog2(TAPS+1)-1:0]  dbg_tap
);
    localparam int TAP_W  = $clog2(TAPS + 1);
    localparam int CNT_W  = $clog2(DECIM + 1);
    localparam int PROD_W = 2 * DATA_SIZE;
    localparam logic signed [PROD_W-1:0] DEQ_DIV = PROD_W'(1) << BITS;

    typedef enum logic [1:0] {
        SHIFT   = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic signed [DATA_SIZE-1:0] line_i [TAPS];
    logic signed [DATA_SIZE-1:0] line_q [TAPS];
    logic [CNT_W-1:0]            dec_cnt;
    logic [TAP_W-1:0]            tap;
    logic signed [DATA_SIZE-1:0] acc_i;
    logic signed [DATA_SIZE-1:0] acc_q;
    logic                        rd_fire;
    logic                        wr_fire;
    logic                        last_sample;
    logic                        last_tap;
    logic signed [DATA_SIZE-1:0] coef;
    logic signed [DATA_SIZE-1:0] samp_i;
    logic signed [DATA_SIZE-1:0] samp_q;
    logic signed [PROD_W-1:0]    prod_i;
    logic signed [PROD_W-1:0]    prod_q;
    logic signed [DATA_SIZE-1:0] term_i;
    logic signed [DATA_SIZE-1:0] term_q;

    assign last_sample = (dec_cnt == CNT_W'(DECIM - 1));
    assign last_tap    = (tap == TAP_W'(TAPS - 1));

    always_comb begin
        state_next = state;
        rd_fire    = 1'b0;
        wr_fire    = 1'b0;
        case (state)
            SHIFT: begin
                if (!bus.i_empty && !bus.q_empty) begin
                    rd_fire = 1'b1;
                    if (last_sample) state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (last_tap) state_next = WRITE;
            end
            WRITE: begin
                if (!bus.i_out_full && !bus.q_out_full) begin
                    wr_fire    = 1'b1;
                    state_next = SHIFT;
                end
            end
            default: state_next = SHIFT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= SHIFT;
        else        state <= state_next;
    end

    // Strobes are gated by reset so neither FIFO sees a stroke while reset is low.
    assign bus.in_rd_en  = rd_fire & reset;
    assign bus.out_wr_en = wr_fire & reset;
    assign bus.i_out     = acc_i;
    assign bus.q_out     = acc_q;
    assign dbg_state     = state;
    assign dbg_tap       = tap;

    // One shared coefficient per cycle; full-width product, then divide
    // (rounds toward zero) and keep the low DATA_SIZE bits.
    assign coef   = $signed(DATA_SIZE'(CHANNEL_COEFFS[tap]));
    assign samp_i = line_i[tap];
    assign samp_q = line_q[tap];
    assign prod_i = PROD_W'(coef) * PROD_W'(samp_i);
    assign prod_q = PROD_W'(coef) * PROD_W'(samp_q);
    assign term_i = DATA_SIZE'(prod_i / DEQ_DIV);
    assign term_q = DATA_SIZE'(prod_q / DEQ_DIV);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec_cnt <= '0;
            tap     <= '0;
            acc_i   <= '0;
            acc_q   <= '0;
            for (int k = 0; k < TAPS; k++) begin
                line_i[k] <= '0;
                line_q[k] <= '0;
            end
        end else begin
            if (rd_fire) begin
                line_i[0] <= bus.i_in;
                line_q[0] <= bus.q_in;
                for (int k = 1; k < TAPS; k++) begin
                    line_i[k] <= line_i[k-1];
                    line_q[k] <= line_q[k-1];
                end
                if (last_sample) begin
                    dec_cnt <= '0;
                    tap     <= '0;
                    acc_i   <= '0;
                    acc_q   <= '0;
                end else begin
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end
            if (state == COMPUTE) begin
                acc_i <= acc_i + term_i;
                acc_q <= acc_q + term_q;
                tap   <= last_tap ? '0 : tap + 1'b1;
            end
        end
    end
endmodule
